// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: load-use bubbles, taken-branch flushes,
// data-memory wait freezes, saturating stall/flush counters and a memory-timeout watchdog.
module hazard_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_counters,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_nop,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StMemWait = 2'b01,
        StTimeout = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [WaitW-1:0]   wait_inc;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               mem_timeout_q;
    logic               load_use, mem_stall, freeze;

    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !mem_ready;
    assign wait_inc  = wait_q + 1'b1;

    always_comb begin
        unique case (state_q)
            StRun:     freeze = mem_stall;
            StMemWait: freeze = !mem_ready;
            default:   freeze = 1'b1;
        endcase
    end

    // Mealy outputs; forced idle while reset is asserted.
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_nop   = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pipe_freeze = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end else if (load_use) begin
                id_ex_nop = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StRun: begin
                wait_d = '0;
                if (mem_stall) state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StRun;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc == WaitW'(MEM_TIMEOUT)) state_d = StTimeout;
                end
            end
            StTimeout: state_d = StTimeout;
            default: begin
                state_d = StRun;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            wait_q        <= '0;
            stall_q       <= '0;
            flush_q       <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            mem_timeout_q <= mem_timeout_q || (state_d == StTimeout);
            if (clr_counters) begin
                stall_q <= '0;
                flush_q <= '0;
            end else begin
                if (!pc_write && (stall_q != '1)) stall_q <= stall_q + 1'b1;
                if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign state       = state_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned CntW    = 3;
    localparam int unsigned Timeout = 4;
    localparam int          CntMax  = (1 << CntW) - 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      id_rs1, id_rs2, ex_rd;
    logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic            mem_req, mem_ready, clr_counters;
    logic            pc_write, if_id_write, if_id_flush, id_ex_nop, id_ex_flush, pipe_freeze;
    logic [1:0]      state;
    logic [CntW-1:0] stall_count, flush_count;
    logic            mem_timeout;

    hazard_ctrl #(.CNT_W(CntW), .MEM_TIMEOUT(Timeout)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .clr_counters   (clr_counters),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_nop      (id_ex_nop),
        .id_ex_flush    (id_ex_flush),
        .pipe_freeze    (pipe_freeze),
        .state          (state),
        .stall_count    (stall_count),
        .flush_count    (flush_count),
        .mem_timeout    (mem_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0 run, 1 waiting on memory, 2 watchdog tripped.
    int m_mode, m_waits, m_stall, m_flush;
    bit m_to;
    bit e_pc, e_ifw, e_iff, e_nop, e_exf, e_frz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_waits = 0;
        m_stall = 0;
        m_flush = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_outputs();
        bit hazard, frozen;
        hazard = ex_mem_read && ex_rd != 0 &&
                 ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        frozen = (m_mode == 2) || (m_mode == 1 && !mem_ready) ||
                 (m_mode == 0 && mem_req && !mem_ready);
        {e_pc, e_ifw, e_iff, e_nop, e_exf, e_frz} = '0;
        if (!rst_n) return;
        if (frozen) e_frz = 1'b1;
        else if (ex_branch_taken) {e_pc, e_ifw, e_iff, e_exf} = 4'b1111;
        else if (hazard) e_nop = 1'b1;
        else {e_pc, e_ifw} = 2'b11;
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (clr_counters) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!e_pc && m_stall < CntMax) m_stall++;
            if (e_iff && m_flush < CntMax) m_flush++;
        end
        case (m_mode)
            0: if (mem_req && !mem_ready) begin m_mode = 1; m_waits = 0; end
            1: if (mem_ready) m_mode = 0;
               else begin
                   m_waits++;
                   if (m_waits >= Timeout) begin m_mode = 2; m_to = 1'b1; end
               end
            default: ;
        endcase
    endtask

    task automatic check_now();
        model_outputs();
        chk("pc_write", pc_write, e_pc);
        chk("if_id_write", if_id_write, e_ifw);
        chk("if_id_flush", if_id_flush, e_iff);
        chk("id_ex_nop", id_ex_nop, e_nop);
        chk("id_ex_flush", id_ex_flush, e_exf);
        chk("pipe_freeze", pipe_freeze, e_frz);
        chk("state", state, m_mode);
        chk("stall_count", stall_count, m_stall);
        chk("flush_count", flush_count, m_flush);
        chk("mem_timeout", mem_timeout, m_to);
    endtask

    // Check at posedge+2, clock, update model, leave time at posedge+1 for new inputs.
    task automatic tick();
        #1;
        check_now();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken} = '0;
        {mem_req, mem_ready, clr_counters} = '0;
    endtask

    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #3;
        check_now();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load-use on rs2, then bubble clears the load; then same with rd=x0.
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
        tick();
        chk("lu_stall_cnt", stall_count, 1);
        ex_mem_read = 1'b0;
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        tick();
        idle_inputs();

        // Taken branch for one cycle.
        ex_branch_taken = 1'b1;
        tick();
        chk("br_flush_cnt", flush_count, 1);
        ex_branch_taken = 1'b0;
        tick();

        // Three-cycle memory wait with a branch held; flush only on release.
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        chk("mw_flush_cnt", flush_count, 2);
        idle_inputs();
        tick();

        // Watchdog: hold mem_ready low until the timeout, then ready is ignored.
        mem_req = 1'b1;
        repeat (Timeout + 1) tick();
        chk("wd_state", state, 2);
        chk("wd_flag", mem_timeout, 1);
        mem_ready = 1'b1;
        repeat (3) tick();
        chk("sat_stall", stall_count, CntMax);
        clr_counters = 1'b1;
        tick();
        chk("clr_stall", stall_count, 0);
        clr_counters = 1'b0;
        tick();
        async_reset();
        chk("rst_state", state, 0);

        // Async reset dropped in the middle of a memory wait.
        idle_inputs();
        mem_req = 1'b1;
        repeat (3) tick();
        async_reset();
        idle_inputs();
        tick();

        for (int i = 0; i < 1500; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            mem_req         = ($urandom_range(0, 2) == 0);
            mem_ready       = ($urandom_range(0, 2) == 0);
            clr_counters    = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 60) == 0) async_reset();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
